// File: rtl/rv_core_pkg.sv
// Shared core constants: bubble word, reset PC and fetch FSM encodings.
package rv_core_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    localparam logic [1:0] FS_BOOT = 2'd0;
    localparam logic [1:0] FS_RUN  = 2'd1;
    localparam logic [1:0] FS_HALT = 2'd2;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// Generic pipeline stage register: bubble beats load, hold otherwise.
module if_id_reg
    import rv_core_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc4,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc4,
    output logic        o_valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_instr <= NOP_INSTR;
            o_pc    <= 32'd0;
            o_pc4   <= 32'd0;
            o_valid <= 1'b0;
        end else if (i_bubble) begin
            o_instr <= NOP_INSTR;
            o_pc    <= 32'd0;
            o_pc4   <= 32'd0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_pc    <= i_pc;
            o_pc4   <= i_pc4;
            o_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, next-PC selection, BOOT/RUN/HALT FSM and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch and bubble event counters.
module fetch_stage
    import rv_core_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        halt_i,
    input  logic [31:0] instr_i,
    output logic [31:0] pc_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc4_o,
    output logic        if_id_valid_o,
    output logic        misalign_o,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] fetch_cnt_o,
    output logic [31:0] bubble_cnt_o,
`endif
    output logic        halted_o
);

    logic [31:0] r_pc;
    logic [1:0]  r_state;
    logic        r_misalign;

    logic [31:0] w_pc4;
    logic [31:0] w_pc_next;
    logic [1:0]  w_state_next;
    logic        w_load;
    logic        w_bubble;
    logic        w_misalign_next;

    assign w_pc4 = r_pc + 32'd4;

    always_comb begin
        w_pc_next       = r_pc;
        w_state_next    = r_state;
        w_load          = 1'b0;
        w_bubble        = 1'b0;
        w_misalign_next = 1'b0;
        case (r_state)
            FS_BOOT: begin
                w_state_next = FS_RUN;
                w_bubble     = 1'b1;
            end
            FS_RUN: begin
                if (redirect_i) begin
                    w_pc_next       = word_align(redirect_pc_i);
                    w_bubble        = 1'b1;
                    w_misalign_next = |redirect_pc_i[1:0];
                end else if (halt_i) begin
                    w_state_next = FS_HALT;
                    w_bubble     = 1'b1;
                end else if (flush_i) begin
                    w_bubble = 1'b1;
                    if (!stall_i) begin
                        w_pc_next = w_pc4;
                    end
                end else if (!stall_i) begin
                    w_load    = 1'b1;
                    w_pc_next = w_pc4;
                end
            end
            FS_HALT: begin
                w_bubble = 1'b1;
                if (redirect_i) begin
                    w_pc_next       = word_align(redirect_pc_i);
                    w_misalign_next = |redirect_pc_i[1:0];
                    w_state_next    = FS_RUN;
                end
            end
            default: begin
                w_state_next = FS_BOOT;
                w_bubble     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_state    <= FS_BOOT;
            r_misalign <= 1'b0;
        end else begin
            r_pc       <= w_pc_next;
            r_state    <= w_state_next;
            r_misalign <= w_misalign_next;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_instr  (instr_i),
        .i_pc     (r_pc),
        .i_pc4    (w_pc4),
        .o_instr  (if_id_instr_o),
        .o_pc     (if_id_pc_o),
        .o_pc4    (if_id_pc4_o),
        .o_valid  (if_id_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_bubble_cnt;

    // Only bubbles inserted while running count; BOOT and HALT idle edges do not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt  <= 32'd0;
            r_bubble_cnt <= 32'd0;
        end else begin
            if (w_load && !w_bubble) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_bubble && (r_state == FS_RUN)) begin
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt_o  = r_fetch_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
`endif

    assign pc_o       = r_pc;
    assign misalign_o = r_misalign;
    assign halted_o   = (r_state == FS_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected IF/ID words queued at drive time, popped after each edge.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        halt_i;
    logic [31:0] instr_i;
    logic [31:0] pc_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic        if_id_valid_o;
    logic        misalign_o;
    logic        halted_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_o;
    logic [31:0] bubble_cnt_o;
`endif

    logic [31:0] rom [0:255];
    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          exp_fetch = 0;
    int          exp_bubble = 0;

    always #5 clk = ~clk;

    assign instr_i = rom[pc_o[9:2]];

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .halt_i        (halt_i),
        .instr_i       (instr_i),
        .pc_o          (pc_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
        .if_id_pc4_o   (if_id_pc4_o),
        .if_id_valid_o (if_id_valid_o),
        .misalign_o    (misalign_o),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt_o   (fetch_cnt_o),
        .bubble_cnt_o  (bubble_cnt_o),
`endif
        .halted_o      (halted_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_i = 0; flush_i = 0; redirect_i = 0; redirect_pc_i = 0; halt_i = 0;
    endtask

    task automatic push_fetch(input logic [31:0] pc);
        sb.push_back('{instr: rom[pc[9:2]], pc: pc, pc4: pc + 32'd4, valid: 1'b1});
        exp_fetch++;
    endtask

    task automatic push_bubble(input bit in_run);
        sb.push_back('{instr: NOP, pc: 32'd0, pc4: 32'd0, valid: 1'b0});
        if (in_run) exp_bubble++;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        clear_inputs();
        #12;
        n_checks++;
        if (pc_o !== 32'd0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'd0 || if_id_pc4_o !== 32'd0
            || if_id_valid_o !== 1'b0 || misalign_o !== 1'b0 || halted_o !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_values: pc=%h instr=%h ifpc=%h pc4=%h v=%b mis=%b halt=%b, need pc=0 instr=%h rest 0",
                     pc_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o, if_id_valid_o, misalign_o, halted_o, NOP);
        end
        @(negedge clk);
        rst = 1'b0;
        push_bubble(0);
        cyc();
        e = sb.pop_front();
        n_checks++;
        if (if_id_valid_o !== e.valid || if_id_instr_o !== e.instr || pc_o !== 32'd0) begin
            n_errors++;
            $display("FAIL boot_cycle: valid=%b instr=%h pc=%h, need valid=0 instr=%h pc=0",
                     if_id_valid_o, if_id_instr_o, pc_o, e.instr);
        end
        $display("[%0t] boot: valid=%b pc_o=%h", $time, if_id_valid_o, pc_o);
    endtask

    task automatic test_fetch();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            push_fetch(32'(4 * k));
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_pc4_o !== e.pc4
                || if_id_valid_o !== e.valid || pc_o !== e.pc4) begin
                n_errors++;
                $display("FAIL fetch_%0d: got %h/%h/%h/%b pc_o=%h, need %h/%h/%h/%b pc_o=%h", k,
                         if_id_instr_o, if_id_pc_o, if_id_pc4_o, if_id_valid_o, pc_o,
                         e.instr, e.pc, e.pc4, e.valid, e.pc4);
            end
            $display("[%0t] fetch: instr=%h pc=%h pc4=%h", $time, if_id_instr_o, if_id_pc_o, if_id_pc4_o);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        logic [31:0] want_pc;
        for (int k = 0; k < 4; k++) begin
            stall_i = (k < 3);
            if (k < 3) begin
                sb.push_back('{instr: rom[1], pc: 32'd4, pc4: 32'd8, valid: 1'b1});
                want_pc = 32'd8;
            end else begin
                push_fetch(32'd8);
                want_pc = 32'd12;
            end
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_pc4_o !== e.pc4
                || if_id_valid_o !== e.valid || pc_o !== want_pc) begin
                n_errors++;
                $display("FAIL stall_%0d: got %h/%h/%h/%b pc_o=%h, need %h/%h/%h/%b pc_o=%h", k,
                         if_id_instr_o, if_id_pc_o, if_id_pc4_o, if_id_valid_o, pc_o,
                         e.instr, e.pc, e.pc4, e.valid, want_pc);
            end
            $display("[%0t] stall=%b: instr=%h pc=%h pc_o=%h", $time, stall_i, if_id_instr_o, if_id_pc_o, pc_o);
        end
        clear_inputs();
    endtask

    task automatic test_redirect_stall();
        exp_t e;
        logic [31:0] want_pc;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h40;
                push_bubble(1);
                want_pc = 32'h40;
            end else begin
                clear_inputs();
                push_fetch(32'h40);
                want_pc = 32'h44;
            end
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_pc4_o !== e.pc4
                || if_id_valid_o !== e.valid || pc_o !== want_pc || misalign_o !== 1'b0) begin
                n_errors++;
                $display("FAIL redirect_stall_%0d: got %h/%h/%h/%b pc_o=%h mis=%b, need %h/%h/%h/%b pc_o=%h mis=0", k,
                         if_id_instr_o, if_id_pc_o, if_id_pc4_o, if_id_valid_o, pc_o, misalign_o,
                         e.instr, e.pc, e.pc4, e.valid, want_pc);
            end
            $display("[%0t] redirect: instr=%h pc=%h v=%b pc_o=%h", $time, if_id_instr_o, if_id_pc_o, if_id_valid_o, pc_o);
        end
    endtask

    task automatic test_perf_cnt();
`ifdef FETCH_PERF_CNT_EN
        n_checks++;
        if (fetch_cnt_o !== 32'(exp_fetch) || bubble_cnt_o !== 32'(exp_bubble)) begin
            n_errors++;
            $display("FAIL perf_cnt: fetch=%0d bubble=%0d, need fetch=%0d bubble=%0d",
                     fetch_cnt_o, bubble_cnt_o, exp_fetch, exp_bubble);
        end
        $display("[%0t] perf: fetch=%0d bubble=%0d", $time, fetch_cnt_o, bubble_cnt_o);
`endif
    endtask

    task automatic test_flush();
        exp_t e;
        logic [31:0] want_pc [0:1];
        want_pc[0] = 32'h48;
        want_pc[1] = 32'h48;
        for (int k = 0; k < 2; k++) begin
            flush_i = 1; stall_i = (k == 1);
            push_bubble(1);
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_valid_o !== e.valid || pc_o !== want_pc[k]) begin
                n_errors++;
                $display("FAIL flush_%0d: instr=%h v=%b pc_o=%h, need instr=%h v=0 pc_o=%h", k,
                         if_id_instr_o, if_id_valid_o, pc_o, e.instr, want_pc[k]);
            end
            $display("[%0t] flush stall=%b: v=%b pc_o=%h", $time, stall_i, if_id_valid_o, pc_o);
        end
        clear_inputs();
    endtask

    task automatic test_misalign();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                redirect_i = 1; redirect_pc_i = 32'h46;
                push_bubble(1);
            end else begin
                clear_inputs();
                push_fetch(32'h44);
            end
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_valid_o !== e.valid
                || pc_o !== (k == 0 ? 32'h44 : 32'h48) || misalign_o !== (k == 0)) begin
                n_errors++;
                $display("FAIL misalign_%0d: got %h/%h/%b pc_o=%h mis=%b, need %h/%h/%b pc_o=%h mis=%b", k,
                         if_id_instr_o, if_id_pc_o, if_id_valid_o, pc_o, misalign_o,
                         e.instr, e.pc, e.valid, (k == 0 ? 32'h44 : 32'h48), (k == 0));
            end
            $display("[%0t] misalign step %0d: pc_o=%h mis=%b", $time, k, pc_o, misalign_o);
        end
    endtask

    task automatic test_halt();
        exp_t e;
        // step: 0..2 halted idle, 3 redirect out of HALT, 4 fetch, 5 halt+redirect, 6 fetch
        logic [31:0] want_pc [0:6];
        logic        want_halt [0:6];
        want_pc   = '{32'h48, 32'h48, 32'h48, 32'h0, 32'h4, 32'h20, 32'h24};
        want_halt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            clear_inputs();
            case (k)
                0, 1: begin halt_i = 1; push_bubble(k == 0); end
                2:    push_bubble(0);
                3:    begin halt_i = 1; redirect_i = 1; redirect_pc_i = 32'h0; push_bubble(0); end
                4:    push_fetch(32'h0);
                5:    begin halt_i = 1; redirect_i = 1; redirect_pc_i = 32'h20; push_bubble(1); end
                default: push_fetch(32'h20);
            endcase
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_valid_o !== e.valid
                || pc_o !== want_pc[k] || halted_o !== want_halt[k]) begin
                n_errors++;
                $display("FAIL halt_%0d: got %h/%h/%b pc_o=%h halted=%b, need %h/%h/%b pc_o=%h halted=%b", k,
                         if_id_instr_o, if_id_pc_o, if_id_valid_o, pc_o, halted_o,
                         e.instr, e.pc, e.valid, want_pc[k], want_halt[k]);
            end
            $display("[%0t] halt step %0d: halted=%b pc_o=%h v=%b", $time, k, halted_o, pc_o, if_id_valid_o);
        end
        clear_inputs();
    endtask

    task automatic test_wrap();
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
                push_bubble(1);
            end else begin
                clear_inputs();
                push_fetch(32'hFFFF_FFFC);
            end
            cyc();
            e = sb.pop_front();
            n_checks++;
            if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_pc4_o !== e.pc4
                || if_id_valid_o !== e.valid || pc_o !== (k == 0 ? 32'hFFFF_FFFC : 32'h0)) begin
                n_errors++;
                $display("FAIL wrap_%0d: got %h/%h/%h/%b pc_o=%h, need %h/%h/%h/%b pc_o=%h", k,
                         if_id_instr_o, if_id_pc_o, if_id_pc4_o, if_id_valid_o, pc_o,
                         e.instr, e.pc, e.pc4, e.valid, (k == 0 ? 32'hFFFF_FFFC : 32'h0));
            end
            $display("[%0t] wrap step %0d: pc=%h pc4=%h pc_o=%h", $time, k, if_id_pc_o, if_id_pc4_o, pc_o);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        push_fetch(32'h0);
        cyc();
        e = sb.pop_front();
        n_checks++;
        if (if_id_instr_o !== e.instr || if_id_valid_o !== e.valid) begin
            n_errors++;
            $display("FAIL pre_reset_fetch: instr=%h v=%b, need %h v=1", if_id_instr_o, if_id_valid_o, e.instr);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (pc_o !== 32'd0 || if_id_valid_o !== 1'b0 || if_id_instr_o !== NOP || if_id_pc_o !== 32'd0
            || halted_o !== 1'b0 || misalign_o !== 1'b0) begin
            n_errors++;
            $display("FAIL async_reset: pc=%h v=%b instr=%h ifpc=%h halt=%b mis=%b, need pc=0 v=0 instr=%h ifpc=0",
                     pc_o, if_id_valid_o, if_id_instr_o, if_id_pc_o, halted_o, misalign_o, NOP);
        end
        $display("[%0t] async reset: pc_o=%h v=%b", $time, pc_o, if_id_valid_o);
        exp_fetch = 0;
        exp_bubble = 0;
        test_perf_cnt();
        @(negedge clk);
        rst = 1'b0;
        push_bubble(0);
        cyc();
        push_fetch(32'h0);
        e = sb.pop_front();
        n_checks++;
        if (if_id_valid_o !== e.valid || pc_o !== 32'd0) begin
            n_errors++;
            $display("FAIL reboot: v=%b pc_o=%h, need v=0 pc_o=0", if_id_valid_o, pc_o);
        end
        cyc();
        e = sb.pop_front();
        n_checks++;
        if (if_id_instr_o !== e.instr || if_id_pc_o !== e.pc || if_id_valid_o !== e.valid || pc_o !== 32'd4) begin
            n_errors++;
            $display("FAIL refetch: got %h/%h/%b pc_o=%h, need %h/%h/1 pc_o=4",
                     if_id_instr_o, if_id_pc_o, if_id_valid_o, pc_o, e.instr, e.pc);
        end
        $display("[%0t] refetch: instr=%h pc=%h", $time, if_id_instr_o, if_id_pc_o);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'hC0DE_0000 + 32'(i * 17);
        test_reset();
        test_fetch();
        test_stall();
        test_redirect_stall();
        test_perf_cnt();
        test_flush();
        test_misalign();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
